// File: rtl/clk_phase_meter_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_phase_meter_if
//  Purpose  : Groups the measurement request, status and result signals of
//             clk_phase_meter.
//  Ports    : sig_in   - CH monitored clock-like signals (async to clk)
//             start    - one-cycle measurement request
//             edge_sel - 1 = rising edge, 0 = falling edge
//             busy     - measurement in progress
//             done     - one-cycle pulse, results valid
//             period   - CH x CW unsigned periods
//             pdiff    - CH x CW period difference against channel 0
//             phase    - CH x CW first-edge delay against channel 0
//             tmo      - CH per-channel timeout flags
//             master   - requester side (drives sig_in/start/edge_sel)
//             slave    - the meter itself
//  Revision : 1.0  initial release
// ============================================================================
interface clk_phase_meter_if #(
   parameter int CH = 2,
   parameter int CW = 16
) ();
   logic [CH-1:0]    sig_in;
   logic             start;
   logic             edge_sel;
   logic             busy;
   logic             done;
   logic [CH*CW-1:0] period;
   logic [CH*CW-1:0] pdiff;
   logic [CH*CW-1:0] phase;
   logic [CH-1:0]    tmo;

   modport master (
      output sig_in, start, edge_sel,
      input  busy, done, period, pdiff, phase, tmo
   );

   modport slave (
      input  sig_in, start, edge_sel,
      output busy, done, period, pdiff, phase, tmo
   );
endinterface
`default_nettype wire

// File: rtl/clk_phase_meter.sv
`default_nettype none
// ============================================================================
//  Module   : clk_phase_meter
//  Purpose  : Multi-channel clock monitor. Measures, in clk cycles, the period
//             of each sampled signal, its period difference against channel 0
//             and the delay of its first selected edge after channel 0's.
//  Ports    : clk - system clock, all logic on its rising edge
//             rst - synchronous active-high reset
//             bus - clk_phase_meter_if.slave (sig_in, start, edge_sel in;
//                   busy, done, period, pdiff, phase, tmo out)
//  Revision : 1.0  initial release
// ============================================================================
module clk_phase_meter #(
   parameter int CH = 2,
   parameter int CW = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   clk_phase_meter_if.slave  bus
);

   localparam logic [CW-1:0] C_TS_MAX = {CW{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ARM  = 2'd1,
      S_MEAS = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state;

   // input conditioning
   logic [CH-1:0]    r_sync1;
   logic [CH-1:0]    r_sync2;
   logic [CH-1:0]    r_prev;
   logic             r_edge_sel;
   logic [CH-1:0]    w_edge;

   // measurement state
   logic [CW-1:0]    r_ts;
   logic [CW-1:0]    r_t1 [CH];
   logic [CW-1:0]    r_t2 [CH];
   logic [CH-1:0]    r_has1;
   logic [CH-1:0]    r_has2;

   // captures including the current cycle's edges
   logic [CW-1:0]    w_t1_nxt [CH];
   logic [CW-1:0]    w_t2_nxt [CH];
   logic [CH-1:0]    w_has1_nxt;
   logic [CH-1:0]    w_has2_nxt;

   logic             w_active;
   logic             w_timeout;
   logic             w_finish;
   logic [CH-1:0]    w_valid;

   // result values computed from the *_nxt captures
   logic [CW-1:0]    w_per [CH];
   logic [CH*CW-1:0] w_period;
   logic [CH*CW-1:0] w_pdiff;
   logic [CH*CW-1:0] w_phase;
   logic [CH-1:0]    w_tmo;

   // registered outputs
   logic             r_busy;
   logic             r_done;
   logic [CH*CW-1:0] r_period;
   logic [CH*CW-1:0] r_pdiff;
   logic [CH*CW-1:0] r_phase;
   logic [CH-1:0]    r_tmo;

   // -------------------------------------------------------------------------
   // Two-flop synchronizer plus previous-value register. Every channel has the
   // same pipeline depth, so relative timings are unaffected by it.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= bus.sig_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge = r_edge_sel ? (r_sync2 & ~r_prev) : (~r_sync2 & r_prev);

   assign w_active  = (r_state == S_ARM) || (r_state == S_MEAS);
   assign w_timeout = w_active && (r_ts == C_TS_MAX);

   // -------------------------------------------------------------------------
   // Capture logic. In ARM only channel 0's first edge opens the window; other
   // channels that see an edge in that very cycle record t1 too. In MEAS a
   // channel without t1 takes it on its first edge, and a channel holding t1
   // takes t2 on its next edge (never in the same cycle as its t1).
   // -------------------------------------------------------------------------
   always_comb begin
      w_has1_nxt = r_has1;
      w_has2_nxt = r_has2;
      for (int i = 0; i < CH; i++) begin
         w_t1_nxt[i] = r_t1[i];
         w_t2_nxt[i] = r_t2[i];
      end
      if (r_state == S_ARM && w_edge[0]) begin
         for (int i = 0; i < CH; i++) begin
            if (w_edge[i]) begin
               w_has1_nxt[i] = 1'b1;
               w_t1_nxt[i]   = r_ts;
            end
         end
      end else if (r_state == S_MEAS) begin
         for (int i = 0; i < CH; i++) begin
            if (w_edge[i]) begin
               if (!r_has1[i]) begin
                  w_has1_nxt[i] = 1'b1;
                  w_t1_nxt[i]   = r_ts;
               end else if (!r_has2[i]) begin
                  w_has2_nxt[i] = 1'b1;
                  w_t2_nxt[i]   = r_ts;
               end
            end
         end
      end
   end

   assign w_valid  = w_has1_nxt & w_has2_nxt;
   assign w_finish = ((r_state == S_MEAS) && (&w_has2_nxt)) || w_timeout;

   // -------------------------------------------------------------------------
   // Result computation. A channel lacking t1 or t2 reports zeros and tmo.
   // pdiff needs both its own and channel 0's period, otherwise it is zero.
   // A valid channel always implies channel 0 holds t1, so phase is sound.
   // -------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_per[i] = w_t2_nxt[i] - w_t1_nxt[i];
      end
   end

   always_comb begin
      w_period = '0;
      w_pdiff  = '0;
      w_phase  = '0;
      w_tmo    = '0;
      for (int i = 0; i < CH; i++) begin
         if (w_valid[i]) begin
            w_period[i*CW +: CW] = w_per[i];
            w_phase[i*CW +: CW]  = w_t1_nxt[i] - w_t1_nxt[0];
            if (w_valid[0]) begin
               w_pdiff[i*CW +: CW] = w_per[i] - w_per[0];
            end
         end else begin
            w_tmo[i] = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM. The result registers are written on the transition into
   // DONE so that they are already valid in the cycle done is high.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_edge_sel <= 1'b0;
         r_ts       <= '0;
         r_has1     <= '0;
         r_has2     <= '0;
         for (int i = 0; i < CH; i++) begin
            r_t1[i] <= '0;
            r_t2[i] <= '0;
         end
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_period   <= '0;
         r_pdiff    <= '0;
         r_phase    <= '0;
         r_tmo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state    <= S_ARM;
                  r_edge_sel <= bus.edge_sel;
                  r_ts       <= '0;
                  r_has1     <= '0;
                  r_has2     <= '0;
                  r_busy     <= 1'b1;
               end
            end
            S_ARM, S_MEAS: begin
               r_has1 <= w_has1_nxt;
               r_has2 <= w_has2_nxt;
               r_t1   <= w_t1_nxt;
               r_t2   <= w_t2_nxt;
               // saturating timestamp; reaching the top is the timeout
               if (r_ts != C_TS_MAX) begin
                  r_ts <= r_ts + 1'b1;
               end
               if (w_finish) begin
                  r_state  <= S_DONE;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_period <= w_period;
                  r_pdiff  <= w_pdiff;
                  r_phase  <= w_phase;
                  r_tmo    <= w_tmo;
               end else if (r_state == S_ARM && w_has1_nxt[0]) begin
                  r_state <= S_MEAS;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.period = r_period;
   assign bus.pdiff  = r_pdiff;
   assign bus.phase  = r_phase;
   assign bus.tmo    = r_tmo;

endmodule
`default_nettype wire
